// File: rtl/ahb_resp_mux_pkg.sv
// rtl/ahb_resp_mux_pkg.sv - shared AHB codes, default-slave states and one-hot slave selects
package ahb_resp_mux_pkg;

  localparam int AHB_DATA_BITS = 32;
  localparam int AHB_NUM_SEL   = 8;

  localparam logic [1:0] AHB_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_TRANS_SEQ    = 2'b11;

  localparam logic [1:0] AHB_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AHB_RESP_ERROR = 2'b01;
  localparam logic [1:0] AHB_RESP_RETRY = 2'b10;
  localparam logic [1:0] AHB_RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dflt_state_e;

  // Bit order {S7..S1,Default}; bit 0 doubles as the reset/zero-hot fallback
  localparam logic [AHB_NUM_SEL-1:0] AHB_SLAVE_DEFAULT = 8'b0000_0001;
  localparam logic [AHB_NUM_SEL-1:0] AHB_SLAVE_S1      = 8'b0000_0010;
  localparam logic [AHB_NUM_SEL-1:0] AHB_SLAVE_S2      = 8'b0000_0100;
  localparam logic [AHB_NUM_SEL-1:0] AHB_SLAVE_S3      = 8'b0000_1000;
  localparam logic [AHB_NUM_SEL-1:0] AHB_SLAVE_S4      = 8'b0001_0000;
  localparam logic [AHB_NUM_SEL-1:0] AHB_SLAVE_S5      = 8'b0010_0000;
  localparam logic [AHB_NUM_SEL-1:0] AHB_SLAVE_S6      = 8'b0100_0000;
  localparam logic [AHB_NUM_SEL-1:0] AHB_SLAVE_S7      = 8'b1000_0000;

  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == AHB_TRANS_NONSEQ) || (htrans == AHB_TRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - AHB default slave answering active transfers with a two-cycle ERROR
module ahb_default_slave
  import ahb_resp_mux_pkg::*;
#(
  parameter int                 DATA_W        = AHB_DATA_BITS,
  parameter logic [DATA_W-1:0]  DEFAULT_RDATA = '0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              hready_i,
  input  logic              hsel_i,
  input  logic [1:0]        htrans_i,
  output logic              hready_o,
  output logic [1:0]        hresp_o,
  output logic [DATA_W-1:0] hrdata_o
);

  dflt_state_e state_q, state_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= D_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ERR2 samples the next address phase exactly like IDLE, enabling back-to-back errors
  always_comb begin
    state_d = state_q;
    case (state_q)
      D_IDLE, D_ERR2: begin
        if (hready_i) begin
          state_d = (hsel_i && is_active_trans(htrans_i)) ? D_ERR1 : D_IDLE;
        end
      end
      D_ERR1:  state_d = D_ERR2;
      default: state_d = D_IDLE;
    endcase
  end

  // Outputs depend on state only, so the muxed HREADY feedback forms no loop
  always_comb begin
    hready_o = 1'b1;
    hresp_o  = AHB_RESP_OKAY;
    hrdata_o = DEFAULT_RDATA;
    case (state_q)
      D_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = AHB_RESP_ERROR;
      end
      D_ERR2:  hresp_o = AHB_RESP_ERROR;
      default: hresp_o = AHB_RESP_OKAY;
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// rtl/ahb_resp_mux.sv - AHB data-phase response mux with registered slave select and default slave
module ahb_resp_mux
  import ahb_resp_mux_pkg::*;
#(
  parameter int                DATA_W        = AHB_DATA_BITS,
  parameter logic [DATA_W-1:0] DEFAULT_RDATA = '0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELDefault,
  input  logic              HSEL_S1,
  input  logic              HSEL_S2,
  input  logic              HSEL_S3,
  input  logic              HSEL_S4,
  input  logic              HSEL_S5,
  input  logic              HSEL_S6,
  input  logic              HSEL_S7,
  input  logic [1:0]        HTRANS,
  input  logic [DATA_W-1:0] HRDATA_S1,
  input  logic [DATA_W-1:0] HRDATA_S2,
  input  logic [DATA_W-1:0] HRDATA_S3,
  input  logic [DATA_W-1:0] HRDATA_S4,
  input  logic [DATA_W-1:0] HRDATA_S5,
  input  logic [DATA_W-1:0] HRDATA_S6,
  input  logic [DATA_W-1:0] HRDATA_S7,
  input  logic              HREADYOUT_S1,
  input  logic              HREADYOUT_S2,
  input  logic              HREADYOUT_S3,
  input  logic              HREADYOUT_S4,
  input  logic              HREADYOUT_S5,
  input  logic              HREADYOUT_S6,
  input  logic              HREADYOUT_S7,
  input  logic [1:0]        HRESP_S1,
  input  logic [1:0]        HRESP_S2,
  input  logic [1:0]        HRESP_S3,
  input  logic [1:0]        HRESP_S4,
  input  logic [1:0]        HRESP_S5,
  input  logic [1:0]        HRESP_S6,
  input  logic [1:0]        HRESP_S7,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic [1:0]        HRESP
);

  logic [AHB_NUM_SEL-1:0] hsel_in;
  logic [AHB_NUM_SEL-1:0] sel_q, sel_d;
  logic                   dflt_hready;
  logic [1:0]             dflt_hresp;
  logic [DATA_W-1:0]      dflt_hrdata;

  assign hsel_in = {HSEL_S7, HSEL_S6, HSEL_S5, HSEL_S4, HSEL_S3, HSEL_S2, HSEL_S1, HSELDefault};

  always_comb begin
    sel_d = sel_q;
    if (HREADY) begin
      sel_d = (hsel_in == '0) ? AHB_SLAVE_DEFAULT : hsel_in;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q <= AHB_SLAVE_DEFAULT;
    end else begin
      sel_q <= sel_d;
    end
  end

  ahb_default_slave #(
    .DATA_W        (DATA_W),
    .DEFAULT_RDATA (DEFAULT_RDATA)
  ) u_default_slave (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .hready_i (HREADY),
    .hsel_i   (HSELDefault),
    .htrans_i (HTRANS),
    .hready_o (dflt_hready),
    .hresp_o  (dflt_hresp),
    .hrdata_o (dflt_hrdata)
  );

  always_comb begin
    HRDATA = dflt_hrdata;
    HREADY = dflt_hready;
    HRESP  = dflt_hresp;
    case (sel_q)
      AHB_SLAVE_S1: begin HRDATA = HRDATA_S1; HREADY = HREADYOUT_S1; HRESP = HRESP_S1; end
      AHB_SLAVE_S2: begin HRDATA = HRDATA_S2; HREADY = HREADYOUT_S2; HRESP = HRESP_S2; end
      AHB_SLAVE_S3: begin HRDATA = HRDATA_S3; HREADY = HREADYOUT_S3; HRESP = HRESP_S3; end
      AHB_SLAVE_S4: begin HRDATA = HRDATA_S4; HREADY = HREADYOUT_S4; HRESP = HRESP_S4; end
      AHB_SLAVE_S5: begin HRDATA = HRDATA_S5; HREADY = HREADYOUT_S5; HRESP = HRESP_S5; end
      AHB_SLAVE_S6: begin HRDATA = HRDATA_S6; HREADY = HREADYOUT_S6; HRESP = HRESP_S6; end
      AHB_SLAVE_S7: begin HRDATA = HRDATA_S7; HREADY = HREADYOUT_S7; HRESP = HRESP_S7; end
      default: begin
        HRDATA = dflt_hrdata;
        HREADY = dflt_hready;
        HRESP  = dflt_hresp;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb/tb_ahb_resp_mux.sv - directed self-checking bench for ahb_resp_mux
module tb_ahb_resp_mux;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [7:0]  hsel_tb;
  logic [1:0]  HTRANS;
  logic [31:0] rdata_s [1:7];
  logic        rdy_s   [1:7];
  logic [1:0]  resp_s  [1:7];
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_resp_mux dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELDefault(hsel_tb[0]),
    .HSEL_S1(hsel_tb[1]), .HSEL_S2(hsel_tb[2]), .HSEL_S3(hsel_tb[3]), .HSEL_S4(hsel_tb[4]),
    .HSEL_S5(hsel_tb[5]), .HSEL_S6(hsel_tb[6]), .HSEL_S7(hsel_tb[7]),
    .HTRANS(HTRANS),
    .HRDATA_S1(rdata_s[1]), .HRDATA_S2(rdata_s[2]), .HRDATA_S3(rdata_s[3]), .HRDATA_S4(rdata_s[4]),
    .HRDATA_S5(rdata_s[5]), .HRDATA_S6(rdata_s[6]), .HRDATA_S7(rdata_s[7]),
    .HREADYOUT_S1(rdy_s[1]), .HREADYOUT_S2(rdy_s[2]), .HREADYOUT_S3(rdy_s[3]), .HREADYOUT_S4(rdy_s[4]),
    .HREADYOUT_S5(rdy_s[5]), .HREADYOUT_S6(rdy_s[6]), .HREADYOUT_S7(rdy_s[7]),
    .HRESP_S1(resp_s[1]), .HRESP_S2(resp_s[2]), .HRESP_S3(resp_s[3]), .HRESP_S4(resp_s[4]),
    .HRESP_S5(resp_s[5]), .HRESP_S6(resp_s[6]), .HRESP_S7(resp_s[7]),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // The decoder guarantees one-hot selects; a multi-hot stimulus is a bench bug
  always @(posedge HCLK) begin
    if (HRESETn && !$onehot0(hsel_tb)) $error("FAIL multihot_sel got %b", hsel_tb);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr(input logic [7:0] sel, input logic [1:0] trans);
    hsel_tb = sel;
    HTRANS  = trans;
  endtask

  task automatic expect_out(input string tag, input logic rdy, input logic [1:0] resp);
    chk({tag, "_hready"}, {31'd0, HREADY}, {31'd0, rdy});
    chk({tag, "_hresp"}, {30'd0, HRESP}, {30'd0, resp});
  endtask

  initial begin
    HRESETn = 1'b0;
    addr(8'h00, 2'b00);
    for (int k = 1; k <= 7; k++) begin
      rdata_s[k] = 32'h1111_1111 * k;
      rdy_s[k]   = 1'b1;
      resp_s[k]  = 2'b00;
    end
    rdata_s[1] = 32'hDEAD_BEEF;
    rdata_s[7] = 32'h1234_5678;

    // Reset values
    @(negedge HCLK);
    expect_out("rst", 1'b1, 2'b00);
    chk("rst_hrdata", HRDATA, 32'h0);
    cyc();
    HRESETn = 1'b1;

    // First transfer after release: S1 read
    addr(8'h02, 2'b10);
    cyc();
    addr(8'h00, 2'b00);
    @(negedge HCLK);
    chk("s1_hrdata", HRDATA, 32'hDEAD_BEEF);
    expect_out("s1", 1'b1, 2'b00);

    // Asynchronous reset in the middle of an S1 wait state
    cyc();
    addr(8'h02, 2'b10);
    cyc();
    addr(8'h00, 2'b00);
    rdy_s[1] = 1'b0;
    @(negedge HCLK);
    chk("s1wait_hready", {31'd0, HREADY}, 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    expect_out("rst_mid", 1'b1, 2'b00);
    chk("rst_mid_hrdata", HRDATA, 32'h0);
    rdy_s[1] = 1'b1;
    HRESETn  = 1'b1;
    cyc();

    // Wait-state hold: S2 stalls 3 cycles while S3 is presented
    addr(8'h04, 2'b10);
    cyc();
    addr(8'h08, 2'b10);
    rdy_s[2] = 1'b0;
    rdata_s[2] = 32'hA0A0_0001;
    @(negedge HCLK);
    chk("s2w1_hready", {31'd0, HREADY}, 32'd0);
    chk("s2w1_hrdata", HRDATA, 32'hA0A0_0001);
    cyc();
    rdata_s[2] = 32'hA0A0_0002;
    @(negedge HCLK);
    chk("s2w2_hready", {31'd0, HREADY}, 32'd0);
    chk("s2w2_hrdata", HRDATA, 32'hA0A0_0002);
    cyc();
    @(negedge HCLK);
    chk("s2w3_hready", {31'd0, HREADY}, 32'd0);
    cyc();
    rdy_s[2] = 1'b1;
    rdata_s[2] = 32'hA0A0_0003;
    @(negedge HCLK);
    chk("s2done_hready", {31'd0, HREADY}, 32'd1);
    chk("s2done_hrdata", HRDATA, 32'hA0A0_0003);
    cyc();
    addr(8'h00, 2'b00);
    rdata_s[3] = 32'h0B0B_0003;
    resp_s[3]  = 2'b10;
    @(negedge HCLK);
    chk("s3_hrdata", HRDATA, 32'h0B0B_0003);
    expect_out("s3_retry", 1'b1, 2'b10);
    cyc();
    resp_s[3] = 2'b00;

    // Default slave two-cycle ERROR; next address (S4) sampled on second cycle
    addr(8'h01, 2'b10);
    cyc();
    addr(8'h10, 2'b10);
    @(negedge HCLK);
    expect_out("err1", 1'b0, 2'b01);
    chk("err1_hrdata", HRDATA, 32'h0);
    cyc();
    @(negedge HCLK);
    expect_out("err2", 1'b1, 2'b01);
    cyc();
    addr(8'h00, 2'b00);
    @(negedge HCLK);
    chk("s4_hrdata", HRDATA, 32'h4444_4444);
    expect_out("s4", 1'b1, 2'b00);
    cyc();

    // Back-to-back unmapped NONSEQ/SEQ: ERR1, ERR2, ERR1, ERR2
    addr(8'h01, 2'b10);
    cyc();
    @(negedge HCLK);
    expect_out("b2b_e1a", 1'b0, 2'b01);
    cyc();
    addr(8'h01, 2'b11);
    @(negedge HCLK);
    expect_out("b2b_e2a", 1'b1, 2'b01);
    cyc();
    addr(8'h00, 2'b00);
    @(negedge HCLK);
    expect_out("b2b_e1b", 1'b0, 2'b01);
    cyc();
    @(negedge HCLK);
    expect_out("b2b_e2b", 1'b1, 2'b01);
    cyc();
    @(negedge HCLK);
    expect_out("b2b_idle", 1'b1, 2'b00);

    // IDLE then BUSY to the default slave: zero-wait OKAY
    addr(8'h01, 2'b00);
    cyc();
    addr(8'h01, 2'b01);
    @(negedge HCLK);
    expect_out("dflt_idle", 1'b1, 2'b00);
    cyc();
    addr(8'h00, 2'b00);
    @(negedge HCLK);
    expect_out("dflt_busy", 1'b1, 2'b00);
    cyc();

    // Reset during ERR1, then a normal S7 read
    addr(8'h01, 2'b10);
    cyc();
    @(negedge HCLK);
    chk("e1_pre_rst_hready", {31'd0, HREADY}, 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    expect_out("rst_err1", 1'b1, 2'b00);
    chk("rst_err1_hrdata", HRDATA, 32'h0);
    addr(8'h80, 2'b10);
    HRESETn = 1'b1;
    cyc();
    addr(8'h00, 2'b00);
    @(negedge HCLK);
    chk("s7_hrdata", HRDATA, 32'h1234_5678);
    expect_out("s7", 1'b1, 2'b00);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
